// File: rtl/core_pkg.sv
// Shared core definitions: ALU operator encodings and datapath geometry.
package core_pkg;

    localparam int unsigned CORE_XLEN   = 32;
    localparam int unsigned CORE_REG_AW = 5;

    // 4-bit ALU operator encodings, common to decode, issue and alu.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: MEM beats WB beats register-file data; x0 never forwarded.
module fwd_mux
    import core_pkg::*;
#(
    parameter int unsigned XLEN   = CORE_XLEN,
    parameter int unsigned REG_AW = CORE_REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic              mem_valid,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data,
    output logic              mem_load_match
);

    logic mem_hit;
    logic wb_hit;

    // Select the youngest in-flight producer of this source register.
    always_comb begin
        mem_hit        = mem_valid && (mem_rd == rs_addr) && (rs_addr != '0);
        wb_hit         = wb_valid  && (wb_rd  == rs_addr) && (rs_addr != '0);
        mem_load_match = mem_hit && mem_is_load;
        if (mem_hit) begin
            fwd_data = mem_data;
        end else if (wb_hit) begin
            fwd_data = wb_data;
        end else begin
            fwd_data = rs_data;
        end
    end

endmodule

// File: rtl/ex_operand_issue.sv
// ID/EX issue register: holds one decoded instruction, forwards operands and stalls on load-use.
module ex_operand_issue
    import core_pkg::*;
#(
    parameter int unsigned XLEN   = CORE_XLEN,
    parameter int unsigned REG_AW = CORE_REG_AW
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_id_valid,
    output logic              o_id_ready,
    input  logic [3:0]        i_id_alu_operator,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic [REG_AW-1:0] i_id_rd_addr,
    input  logic [XLEN-1:0]   i_id_rs1_data,
    input  logic [XLEN-1:0]   i_id_rs2_data,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic              i_id_use_imm,
    input  logic              i_id_reg_write,
    input  logic              i_id_is_load,
    input  logic              i_fwd_mem_valid,
    input  logic              i_fwd_mem_is_load,
    input  logic [REG_AW-1:0] i_fwd_mem_rd,
    input  logic [XLEN-1:0]   i_fwd_mem_data,
    input  logic              i_fwd_wb_valid,
    input  logic [REG_AW-1:0] i_fwd_wb_rd,
    input  logic [XLEN-1:0]   i_fwd_wb_data,
    input  logic              i_flush,
    input  logic              i_ex_ready,
    output logic              o_ex_valid,
    output logic [3:0]        o_alu_operator,
    output logic [XLEN-1:0]   o_alu_operand_1,
    output logic [XLEN-1:0]   o_alu_operand_2,
    output logic [XLEN-1:0]   o_ex_store_data,
    output logic [REG_AW-1:0] o_ex_rd_addr,
    output logic              o_ex_reg_write,
    output logic              o_ex_is_load
);

    logic              r_valid;
    logic [3:0]        r_operator;
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [REG_AW-1:0] r_rd_addr;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic              r_use_imm;
    logic              r_reg_write;
    logic              r_is_load;

    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;
    logic              w_mem_load_rs1;
    logic              w_mem_load_rs2;
    logic              w_load_use;
    logic              w_transfer;
    logic              w_capture;

    fwd_mux #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fwd_rs1 (
        .rs_addr        (r_rs1_addr),
        .rs_data        (r_rs1_data),
        .mem_valid      (i_fwd_mem_valid),
        .mem_is_load    (i_fwd_mem_is_load),
        .mem_rd         (i_fwd_mem_rd),
        .mem_data       (i_fwd_mem_data),
        .wb_valid       (i_fwd_wb_valid),
        .wb_rd          (i_fwd_wb_rd),
        .wb_data        (i_fwd_wb_data),
        .fwd_data       (w_fwd_rs1),
        .mem_load_match (w_mem_load_rs1)
    );

    fwd_mux #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fwd_rs2 (
        .rs_addr        (r_rs2_addr),
        .rs_data        (r_rs2_data),
        .mem_valid      (i_fwd_mem_valid),
        .mem_is_load    (i_fwd_mem_is_load),
        .mem_rd         (i_fwd_mem_rd),
        .mem_data       (i_fwd_mem_data),
        .wb_valid       (i_fwd_wb_valid),
        .wb_rd          (i_fwd_wb_rd),
        .wb_data        (i_fwd_wb_data),
        .fwd_data       (w_fwd_rs2),
        .mem_load_match (w_mem_load_rs2)
    );

    // Handshake, hazard and operand selection; rs2 is always treated as a used source.
    always_comb begin
        w_load_use      = w_mem_load_rs1 || w_mem_load_rs2;
        o_ex_valid      = r_valid && !w_load_use;
        w_transfer      = o_ex_valid && i_ex_ready;
        o_id_ready      = !r_valid || w_transfer;
        w_capture       = i_id_valid && o_id_ready && !i_flush;
        o_alu_operator  = r_operator;
        o_alu_operand_1 = w_fwd_rs1;
        o_alu_operand_2 = r_use_imm ? r_imm : w_fwd_rs2;
        o_ex_store_data = w_fwd_rs2;
        o_ex_rd_addr    = r_rd_addr;
        o_ex_reg_write  = r_reg_write;
        o_ex_is_load    = r_is_load;
    end

    // Issue register: flush beats capture, capture beats drain, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid     <= 1'b0;
            r_operator  <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_reg_write <= 1'b0;
            r_is_load   <= 1'b0;
        end else if (i_flush) begin
            r_valid     <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_operator  <= i_id_alu_operator;
            r_rs1_addr  <= i_id_rs1_addr;
            r_rs2_addr  <= i_id_rs2_addr;
            r_rd_addr   <= i_id_rd_addr;
            r_rs1_data  <= i_id_rs1_data;
            r_rs2_data  <= i_id_rs2_data;
            r_imm       <= i_id_imm;
            r_use_imm   <= i_id_use_imm;
            r_reg_write <= i_id_reg_write;
            r_is_load   <= i_id_is_load;
        end else if (w_transfer) begin
            r_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_operand_issue.sv
// Self-checking bench for ex_operand_issue: directed scenarios plus randomized traffic vs. a reference model.
module tb_ex_operand_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, id_ready;
    logic [3:0]  id_op;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_d1, id_d2, id_imm;
    logic        id_use_imm, id_rw, id_ld;
    logic        mem_valid, mem_ld;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush, ex_ready;
    logic        ex_valid;
    logic [3:0]  alu_op;
    logic [31:0] op1, op2, store_data;
    logic [4:0]  ex_rd;
    logic        ex_rw, ex_ld;

    int unsigned total = 0;
    int unsigned bad = 0;

    // Reference model: the single instruction the issue stage should be holding.
    logic        m_valid;
    logic [3:0]  m_op;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_d1, m_d2, m_imm;
    logic        m_use_imm, m_rw, m_ld;

    always #5 clk = ~clk;

    ex_operand_issue #(
        .XLEN   (32),
        .REG_AW (5)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_id_valid        (id_valid),
        .o_id_ready        (id_ready),
        .i_id_alu_operator (id_op),
        .i_id_rs1_addr     (id_rs1),
        .i_id_rs2_addr     (id_rs2),
        .i_id_rd_addr      (id_rd),
        .i_id_rs1_data     (id_d1),
        .i_id_rs2_data     (id_d2),
        .i_id_imm          (id_imm),
        .i_id_use_imm      (id_use_imm),
        .i_id_reg_write    (id_rw),
        .i_id_is_load      (id_ld),
        .i_fwd_mem_valid   (mem_valid),
        .i_fwd_mem_is_load (mem_ld),
        .i_fwd_mem_rd      (mem_rd),
        .i_fwd_mem_data    (mem_data),
        .i_fwd_wb_valid    (wb_valid),
        .i_fwd_wb_rd       (wb_rd),
        .i_fwd_wb_data     (wb_data),
        .i_flush           (flush),
        .i_ex_ready        (ex_ready),
        .o_ex_valid        (ex_valid),
        .o_alu_operator    (alu_op),
        .o_alu_operand_1   (op1),
        .o_alu_operand_2   (op2),
        .o_ex_store_data   (store_data),
        .o_ex_rd_addr      (ex_rd),
        .o_ex_reg_write    (ex_rw),
        .o_ex_is_load      (ex_ld)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value a source register should read as, given the results still in flight.
    function automatic logic [31:0] src_value(input logic [4:0] rs, input logic [31:0] raw);
        if (rs == 5'd0) return raw;
        if (mem_valid && mem_rd == rs) return mem_data;
        if (wb_valid && wb_rd == rs) return wb_data;
        return raw;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_d1 = '0; m_d2 = '0; m_imm = '0; m_use_imm = 0; m_rw = 0; m_ld = 0;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_d1 = '0; id_d2 = '0; id_imm = '0; id_use_imm = 0; id_rw = 0; id_ld = 0;
        mem_valid = 0; mem_ld = 0; mem_rd = '0; mem_data = '0;
        wb_valid = 0; wb_rd = '0; wb_data = '0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic use_imm);
        id_valid = 1; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_d1 = d1; id_d2 = d2; id_imm = imm; id_use_imm = use_imm; id_rw = 1; id_ld = 0;
    endtask

    // Called shortly after a falling edge with inputs set: checks outputs, then advances one clock.
    task automatic cycle();
        logic        hazard, exp_valid, exp_ready, take;
        logic [31:0] v1, v2;
        #1;
        v1 = src_value(m_rs1, m_d1);
        v2 = src_value(m_rs2, m_d2);
        hazard = mem_valid && mem_ld && mem_rd != 5'd0 && (mem_rd == m_rs1 || mem_rd == m_rs2);
        exp_valid = m_valid && !hazard;
        exp_ready = !m_valid || (exp_valid && ex_ready);
        check("ex_valid", {31'd0, ex_valid}, {31'd0, exp_valid});
        check("id_ready", {31'd0, id_ready}, {31'd0, exp_ready});
        if (m_valid) begin
            check("operator", {28'd0, alu_op}, {28'd0, m_op});
            check("operand_1", op1, v1);
            check("operand_2", op2, m_use_imm ? m_imm : v2);
            check("store_data", store_data, v2);
            check("rd_addr", {27'd0, ex_rd}, {27'd0, m_rd});
            check("flags", {30'd0, ex_rw, ex_ld}, {30'd0, m_rw, m_ld});
        end
        take = id_valid && exp_ready && !flush;
        @(posedge clk);
        if (flush) begin
            m_valid = 0;
        end else if (take) begin
            m_valid = 1; m_op = id_op; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_d1 = id_d1; m_d2 = id_d2; m_imm = id_imm; m_use_imm = id_use_imm;
            m_rw = id_rw; m_ld = id_ld;
        end else if (exp_valid && ex_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #12;
        check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_id_ready", {31'd0, id_ready}, 32'd1);
        check("reset_operand_1", op1, 32'd0);
        check("reset_operator", {28'd0, alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Plain issue
        offer(4'b0000, 5'd1, 5'd2, 5'd3, 32'hF0000003, 32'h3, 32'h0, 0);
        cycle();
        idle_inputs();
        #1;
        check("plain_op1", op1, 32'hF0000003);
        check("plain_op2", op2, 32'h00000003);
        check("plain_valid", {31'd0, ex_valid}, 32'd1);
        cycle();

        // MEM over WB priority, then x0 not forwarded
        idle_inputs();
        offer(4'b0001, 5'd5, 5'd9, 5'd4, 32'h1111, 32'h2222, 32'h0, 0);
        cycle();
        idle_inputs();
        mem_valid = 1; mem_rd = 5'd5; mem_data = 32'hAAAA;
        wb_valid = 1; wb_rd = 5'd5; wb_data = 32'hBBBB;
        offer(4'b0001, 5'd0, 5'd9, 5'd4, 32'h1234, 32'h2222, 32'h0, 0);
        #1;
        check("prio_op1", op1, 32'hAAAA);
        cycle();
        mem_rd = 5'd0; wb_rd = 5'd0;
        id_valid = 0;
        #1;
        check("x0_op1", op1, 32'h1234);
        cycle();

        // Immediate select with rs2 forwarded from MEM
        idle_inputs();
        offer(4'b0000, 5'd1, 5'd3, 5'd6, 32'h10, 32'h20, 32'hFFFFFFF8, 1);
        cycle();
        idle_inputs();
        mem_valid = 1; mem_rd = 5'd3; mem_data = 32'hCAFE0003;
        #1;
        check("imm_op2", op2, 32'hFFFFFFF8);
        check("imm_store", store_data, 32'hCAFE0003);
        cycle();

        // Load-use: one bubble, then WB supplies the data
        idle_inputs();
        offer(4'b0000, 5'd7, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 0);
        cycle();
        idle_inputs();
        mem_valid = 1; mem_ld = 1; mem_rd = 5'd7; mem_data = 32'hDEAD;
        #1;
        check("lu_stall_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_stall_ready", {31'd0, id_ready}, 32'd0);
        cycle();
        idle_inputs();
        wb_valid = 1; wb_rd = 5'd7; wb_data = 32'h7F;
        #1;
        check("lu_after_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_after_op1", op1, 32'h7F);
        cycle();

        // Backpressure for three cycles, then flush with a simultaneous offer
        idle_inputs();
        offer(4'b1000, 5'd2, 5'd3, 5'd9, 32'h55, 32'h66, 32'h0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            ex_ready = 0;
            offer(4'b0101, 5'd4, 5'd4, 5'd4, 32'h9, 32'h9, 32'h0, 0);
            #1;
            check("bp_ready", {31'd0, id_ready}, 32'd0);
            check("bp_op1", op1, 32'h55);
            cycle();
        end
        flush = 1;
        cycle();
        idle_inputs();
        #1;
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        cycle();

        // Reset while holding an instruction
        idle_inputs();
        ex_ready = 0;
        offer(4'b1001, 5'd6, 5'd7, 5'd8, 32'h77, 32'h88, 32'h99, 0);
        cycle();
        #2;
        rst_n = 0;
        #1;
        check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_mid_op1", op1, 32'd0);
        check("rst_mid_op2", op2, 32'd0);
        check("rst_mid_operator", {28'd0, alu_op}, 32'd0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_after_ready", {31'd0, id_ready}, 32'd1);
        check("rst_after_valid", {31'd0, ex_valid}, 32'd0);
        @(negedge clk);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            id_valid   = ($urandom_range(0, 9) < 7);
            id_op      = 4'($urandom_range(0, 15));
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            id_rd      = 5'($urandom_range(0, 31));
            id_d1      = $urandom;
            id_d2      = $urandom;
            id_imm     = $urandom;
            id_use_imm = 1'($urandom_range(0, 1));
            id_rw      = 1'($urandom_range(0, 1));
            id_ld      = 1'($urandom_range(0, 1));
            mem_valid  = 1'($urandom_range(0, 1));
            mem_ld     = ($urandom_range(0, 3) == 0);
            mem_rd     = 5'($urandom_range(0, 7));
            mem_data   = $urandom;
            wb_valid   = 1'($urandom_range(0, 1));
            wb_rd      = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            flush      = ($urandom_range(0, 15) == 0);
            ex_ready   = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
